// File: rtl/ringosc_meas_ctrl.sv
// Measurement controller for N ring-oscillator channels: gate window, oscillator
// reset/halt schedule, per-gate count snapshot and UART frame launch.
module ringosc_meas_ctrl #(
  parameter int unsigned CLK_RATE    = 10000000,
  parameter int unsigned GATE_CYCLES = CLK_RATE,
  parameter int unsigned N_CH        = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned HALT_EVERY  = 30,
  parameter int unsigned HALT_GATES  = 1,
  parameter int unsigned MIN_COUNT   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [N_CH*CNT_W-1:0] osc_cnt_i,
  input  logic                  tx_busy_i,
  output logic                  osc_rst_o,
  output logic                  osc_halt_o,
  output logic                  tx_start_o,
  output logic [N_CH*CNT_W-1:0] tx_data_o,
  output logic [N_CH-1:0]       fault_o,
  output logic                  overrun_o,
  output logic [15:0]           sample_cnt_o
);

  localparam int G_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int H_W  = (HALT_EVERY > 1) ? $clog2(HALT_EVERY) : 1;
  localparam int HG_W = (HALT_GATES > 1) ? $clog2(HALT_GATES) : 1;

  localparam logic [G_W-1:0]   G_LAST  = G_W'(GATE_CYCLES - 1);
  localparam logic [H_W-1:0]   H_LAST  = H_W'((HALT_EVERY > 0) ? HALT_EVERY - 1 : 0);
  localparam logic [HG_W-1:0]  HG_LAST = HG_W'(HALT_GATES - 1);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [G_W-1:0]   gate, gate_next;
  logic [H_W-1:0]   sched, sched_next;
  logic [HG_W-1:0]  halt_gate, halt_gate_next;
  logic             gate_end;
  logic             snap;
  logic [N_CH-1:0]  fault_next;

  always_comb begin
    state_next     = state;
    gate_next      = gate;
    sched_next     = sched;
    halt_gate_next = halt_gate;
    snap           = 1'b0;
    gate_end       = (gate == G_LAST);

    case (state)
      IDLE: begin
        gate_next      = '0;
        sched_next     = '0;
        halt_gate_next = '0;
        if (enable_i) state_next = RUN;
      end
      RUN: begin
        gate_next = gate_end ? '0 : gate + 1'b1;
        if (gate_end) begin
          snap       = 1'b1;
          sched_next = sched + 1'b1;
          if ((HALT_EVERY != 0) && (sched == H_LAST)) begin
            sched_next     = '0;
            halt_gate_next = '0;
            state_next     = HALT;
          end
        end
      end
      HALT: begin
        gate_next = gate_end ? '0 : gate + 1'b1;
        if (gate_end) begin
          if (halt_gate == HG_LAST) begin
            halt_gate_next = '0;
            state_next     = RUN;
          end else begin
            halt_gate_next = halt_gate + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Dropping enable overrides everything, including a coincident snapshot.
    if (!enable_i && (state != IDLE)) begin
      state_next     = IDLE;
      gate_next      = '0;
      sched_next     = '0;
      halt_gate_next = '0;
      snap           = 1'b0;
    end
  end

  always_comb begin
    fault_next = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      fault_next[k] = (osc_cnt_i[k*CNT_W +: CNT_W] < MIN_C);
    end
  end

  // Outputs are derived from the next-state values so they line up with the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      gate         <= '0;
      sched        <= '0;
      halt_gate    <= '0;
      osc_halt_o   <= 1'b1;
      osc_rst_o    <= 1'b1;
      tx_start_o   <= 1'b0;
      tx_data_o    <= '0;
      fault_o      <= '0;
      overrun_o    <= 1'b0;
      sample_cnt_o <= '0;
    end else begin
      state      <= state_next;
      gate       <= gate_next;
      sched      <= sched_next;
      halt_gate  <= halt_gate_next;
      osc_halt_o <= (state_next != RUN);
      osc_rst_o  <= (state_next != RUN) || (gate_next == '0);
      tx_start_o <= snap && !tx_busy_i;
      if (snap) begin
        tx_data_o    <= osc_cnt_i;
        fault_o      <= fault_next;
        sample_cnt_o <= sample_cnt_o + 16'd1;
      end
      if (state_next == IDLE) begin
        overrun_o <= 1'b0;
      end else if (snap && tx_busy_i) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Scoreboard bench for ringosc_meas_ctrl: expected frames are queued by the
// stimulus process and checked by a monitor whenever tx_start_o pulses.
module tb_ringosc_meas_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] osc_cnt;
  logic        tx_busy;
  logic        osc_rst;
  logic        osc_halt;
  logic        tx_start;
  logic [31:0] tx_data;
  logic [1:0]  fault;
  logic        overrun;
  logic [15:0] sample_cnt;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  fault;
    logic [15:0] sample;
  } frame_t;

  frame_t exp_q[$];

  ringosc_meas_ctrl #(
    .CLK_RATE   (10000000),
    .GATE_CYCLES(8),
    .N_CH       (2),
    .CNT_W      (16),
    .HALT_EVERY (3),
    .HALT_GATES (2),
    .MIN_COUNT  (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .osc_cnt_i   (osc_cnt),
    .tx_busy_i   (tx_busy),
    .osc_rst_o   (osc_rst),
    .osc_halt_o  (osc_halt),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .fault_o     (fault),
    .overrun_o   (overrun),
    .sample_cnt_o(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] cnt, input logic busy);
    enable  = en;
    osc_cnt = cnt;
    tx_busy = busy;
  endtask

  task automatic expectFrame(input logic [31:0] data, input logic [1:0] flt,
                             input logic [15:0] sample);
    frame_t f;
    f.data   = data;
    f.fault  = flt;
    f.sample = sample;
    exp_q.push_back(f);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_halt"},    32'(osc_halt),   32'd1);
    checkOutput({tag, "_rst"},     32'(osc_rst),    32'd1);
    checkOutput({tag, "_start"},   32'(tx_start),   32'd0);
    checkOutput({tag, "_data"},    tx_data,         32'd0);
    checkOutput({tag, "_fault"},   32'(fault),      32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun),    32'd0);
    checkOutput({tag, "_sample"},  32'(sample_cnt), 32'd0);
  endtask

  // Monitor: every start pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("tx_start_unexpected", 32'(tx_start), 32'd0);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        checkOutput("frame_data",   tx_data,         f.data);
        checkOutput("frame_fault",  32'(fault),      32'(f.fault));
        checkOutput("frame_sample", 32'(sample_cnt), 32'(f.sample));
        checkOutput("frame_with_osc_rst", 32'(osc_rst), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    step(2);
    checkResetValues("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput("idle_halt", 32'(osc_halt), 32'd1);
      checkOutput("idle_rst",  32'(osc_rst),  32'd1);
    end
    checkOutput("idle_sample", 32'(sample_cnt), 32'd0);

    // n=0: enable, first gate occupies n=1..8, frame at n=9
    applyStimulus(1'b1, 32'h0100_0200, 1'b0);
    step(1);
    checkOutput("run_halt_low", 32'(osc_halt), 32'd0);
    checkOutput("run_g0_rst",   32'(osc_rst),  32'd1);
    step(1);
    checkOutput("run_g1_rst", 32'(osc_rst), 32'd0);
    step(6);
    expectFrame(32'h0100_0200, 2'b00, 16'd1);
    step(8);
    expectFrame(32'h0100_0200, 2'b00, 16'd2);
    step(8);
    expectFrame(32'h0100_0200, 2'b00, 16'd3);
    step(1);
    checkOutput("halt_entry_halt", 32'(osc_halt), 32'd1);
    step(15);
    checkOutput("halt_last_halt", 32'(osc_halt), 32'd1);
    checkOutput("halt_last_rst",  32'(osc_rst),  32'd1);
    checkOutput("halt_sample",    32'(sample_cnt), 32'd3);
    step(1);
    // n=41: RUN resumes at g=0; busy away from the snapshot edge is ignored
    checkOutput("resume_halt", 32'(osc_halt), 32'd0);
    checkOutput("resume_rst",  32'(osc_rst),  32'd1);
    applyStimulus(1'b1, 32'h0100_0200, 1'b1);
    step(1);
    checkOutput("resume_g1_rst", 32'(osc_rst), 32'd0);
    step(5);
    applyStimulus(1'b1, 32'h0100_0200, 1'b0);
    step(1);
    checkOutput("busy_off_edge_overrun", 32'(overrun), 32'd0);
    expectFrame(32'h0100_0200, 2'b00, 16'd4);
    step(1);
    applyStimulus(1'b1, 32'h0003_0004, 1'b0);
    step(7);
    expectFrame(32'h0003_0004, 2'b10, 16'd5);
    step(1);
    applyStimulus(1'b1, 32'h1234_5678, 1'b0);
    step(7);
    applyStimulus(1'b1, 32'h1234_5678, 1'b1);
    step(1);
    // n=65: busy snapshot that also enters HALT
    checkOutput("busy_no_start", 32'(tx_start),   32'd0);
    checkOutput("busy_overrun",  32'(overrun),    32'd1);
    checkOutput("busy_data",     tx_data,         32'h1234_5678);
    checkOutput("busy_fault",    32'(fault),      32'd0);
    checkOutput("busy_sample",   32'(sample_cnt), 32'd6);
    checkOutput("busy_halt",     32'(osc_halt),   32'd1);
    applyStimulus(1'b1, 32'hAAAA_BBBB, 1'b0);
    step(23);
    // n=88: RUN with g=7; drop enable before the snapshot edge
    checkOutput("overrun_sticky", 32'(overrun), 32'd1);
    applyStimulus(1'b0, 32'hAAAA_BBBB, 1'b0);
    step(1);
    checkOutput("drop_halt",   32'(osc_halt),   32'd1);
    checkOutput("drop_rst",    32'(osc_rst),    32'd1);
    checkOutput("drop_start",  32'(tx_start),   32'd0);
    checkOutput("drop_data",   tx_data,         32'h1234_5678);
    checkOutput("drop_sample", 32'(sample_cnt), 32'd6);
    step(1);
    checkOutput("idle_overrun_clear", 32'(overrun), 32'd0);
    applyStimulus(1'b1, 32'h0F0F_0001, 1'b0);
    step(8);
    applyStimulus(1'b1, 32'h0F0F_0001, 1'b1);
    step(1);
    // n=99: another busy snapshot, channel 0 below threshold
    checkOutput("busy2_no_start", 32'(tx_start),   32'd0);
    checkOutput("busy2_overrun",  32'(overrun),    32'd1);
    checkOutput("busy2_data",     tx_data,         32'h0F0F_0001);
    checkOutput("busy2_fault",    32'(fault),      32'd1);
    checkOutput("busy2_sample",   32'(sample_cnt), 32'd7);
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    applyStimulus(1'b0, 32'h0, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);
    checkOutput("post_reset_halt",   32'(osc_halt),   32'd1);
    checkOutput("post_reset_sample", 32'(sample_cnt), 32'd0);
    checkOutput("frames_pending",    32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
